// File: rtl/ghash_core_stage_pkg.sv
// Shared GHASH definitions: block width, GCM reduction constant and the
// mapping from polynomial coefficient to vector bit (GCM uses reflected order).
package ghash_core_stage_pkg;

  localparam int NB_BLOCK = 128;

  // x^128 + x^7 + x^2 + x + 1, expressed in reflected bit order
  localparam logic [NB_BLOCK-1:0] GCM_R = {8'hE1, 120'h0};

  // Coefficient of x^idx lives at vector bit (NB_BLOCK-1-idx)
  function automatic logic [6:0] gcm_bit_index(input int idx);
    return 7'(NB_BLOCK - 1 - idx);
  endfunction

endpackage

// File: rtl/ghash_core_stage_gf128_multiplier.sv
// Fully combinational GF(2^128) multiply in GCM bit order (shift-and-add
// with on-the-fly reduction, scanning X from the x^0 coefficient upward).
module gf128_multiplier
  import ghash_core_stage_pkg::*;
(
  input  logic [NB_BLOCK-1:0] x_i,
  input  logic [NB_BLOCK-1:0] h_i,
  output logic [NB_BLOCK-1:0] p_o
);

  logic [NB_BLOCK-1:0] z_acc;
  logic [NB_BLOCK-1:0] v_acc;

  always_comb begin
    z_acc = '0;
    v_acc = h_i;
    for (int i = 0; i < NB_BLOCK; i++) begin
      if (x_i[gcm_bit_index(i)]) begin
        z_acc = z_acc ^ v_acc;
      end
      // Multiply V by x; a carry out of x^127 folds back in via R
      v_acc = v_acc[0] ? ((v_acc >> 1) ^ GCM_R) : (v_acc >> 1);
    end
  end

  assign p_o = z_acc;

endmodule

// File: rtl/ghash_core_stage.sv
// One GHASH stage: Y <= (X ^ Xprev) * H, registered, with hold when not valid.
// Chain stages by feeding o_data_y into the next stage's i_data_x_prev.
module ghash_core_stage
  import ghash_core_stage_pkg::*;
#(
  parameter int NB_DATA = NB_BLOCK
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic [NB_DATA-1:0] o_data_y,
  input  logic [NB_DATA-1:0] i_data_x,
  input  logic [NB_DATA-1:0] i_data_x_prev,
  input  logic [NB_DATA-1:0] i_h_key,
  input  logic               i_valid
);

  logic [NB_DATA-1:0] x_sum;
  logic [NB_DATA-1:0] product;
  logic [NB_DATA-1:0] y_q;
  logic [NB_DATA-1:0] y_d;

  assign x_sum = i_data_x ^ i_data_x_prev;

  gf128_multiplier u_mul (
    .x_i (x_sum),
    .h_i (i_h_key),
    .p_o (product)
  );

  always_comb begin
    y_d = y_q;
    if (i_valid) begin
      y_d = product;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign o_data_y = y_q;

endmodule

// File: tb/tb_ghash_core_stage.sv
// Five-stage GHASH chain bench: stimulus pushes expected register values into
// a scoreboard; a negedge monitor pops and compares them against the chain.
module tb_ghash_core_stage;

  localparam int NS = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid;
  logic [127:0] h;
  logic [127:0] xprev0;
  logic [127:0] x [NS];
  logic [127:0] y [NS];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NS; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      ghash_core_stage u_dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_data_y      (y[gi]),
        .i_data_x      (x[gi]),
        .i_data_x_prev (xprev0),
        .i_h_key       (h),
        .i_valid       (valid)
      );
    end else begin : g_next
      ghash_core_stage u_dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .o_data_y      (y[gi]),
        .i_data_x      (x[gi]),
        .i_data_x_prev (y[gi-1]),
        .i_h_key       (h),
        .i_valid       (valid)
      );
    end
  end

  // Reference: convert to natural polynomial order, carry-less multiply,
  // reduce modulo x^128 + x^7 + x^2 + x + 1, convert back.
  function automatic logic [127:0] gf_mul_ref(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar, br, r;
    logic [254:0] p;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ar[i]) p = p ^ (255'(br) << i);
    for (int d = 254; d >= 128; d--)
      if (p[d]) p = p ^ (255'(1) << d) ^ (255'(8'h87) << (d - 128));
    for (int i = 0; i < 128; i++) r[127-i] = p[i];
    return r;
  endfunction

  typedef struct {
    int           due;
    int           stage;
    logic [127:0] val;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  logic         end_check = 1'b0;
  logic         end_done = 1'b0;
  logic [127:0] model [NS];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        vectors++;
        if (y[sb[i].stage] !== sb[i].val) begin
          miscompares++;
          $display("FAIL %s stage%0d cyc%0d: got %h want %h",
                   sb[i].tag, sb[i].stage, cyc, y[sb[i].stage], sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        miscompares++;
        $display("FAIL %s stage%0d expired: due %0d now %0d", sb[i].tag, sb[i].stage, sb[i].due, cyc);
        sb.delete(i);
      end
    end
    if (end_check && !end_done) begin
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      end_done = 1'b1;
    end
  end

  // Advance one edge, predicting every stage register from the chain behaviour
  task automatic apply();
    logic [127:0] nxt [NS];
    logic [127:0] prev;
    for (int k = 0; k < NS; k++) begin
      prev = (k == 0) ? xprev0 : model[k-1];
      if (rst)        nxt[k] = '0;
      else if (valid) nxt[k] = gf_mul_ref(x[k] ^ prev, h);
      else            nxt[k] = model[k];
    end
    for (int k = 0; k < NS; k++) begin
      model[k] = nxt[k];
      sb.push_back('{cyc + 1, k, nxt[k], "model"});
    end
    @(posedge clk);
    #1;
  endtask

  // Check a stage against a fixed constant at the coming negedge
  task automatic expect_now(input int stage, input logic [127:0] val, input string tag);
    sb.push_back('{cyc, stage, val, tag});
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic randomize_inputs();
    h = rnd128();
    xprev0 = rnd128();
    for (int k = 0; k < NS; k++) x[k] = rnd128();
  endtask

  localparam logic [127:0] ID_X   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ONE    = 128'h80000000000000000000000000000000;
  localparam logic [127:0] CH_H   = 128'hacbef20579b4b8ebce889bac8732dad7;
  localparam logic [127:0] CH_OUT = 128'h4db870d37cb75fcb46097c36230d1612;

  task automatic load_chain();
    h = CH_H;
    xprev0 = '0;
    x[0] = 128'h522dc1f099567d07f47f37a32a84427d;
    x[1] = 128'h643a8cdcbfe5c0c97598a2bd2555d1aa;
    x[2] = 128'h8cb08e48590dbb3da7b08b1056828838;
    x[3] = 128'hc5f61e6393ba7a0abcc9f662898015ad;
    x[4] = 128'h00000000000000000000000000000200;
  endtask

  initial begin
    for (int k = 0; k < NS; k++) model[k] = '0;
    randomize_inputs();
    rst = 1'b1;
    valid = 1'b0;

    // Reset with arbitrary inputs, then reset together with valid
    apply();
    randomize_inputs();
    apply();
    expect_now(0, '0, "reset");
    valid = 1'b1;
    randomize_inputs();
    apply();
    expect_now(NS-1, '0, "reset_over_valid");

    // Identity key and self-cancelling input
    rst = 1'b0;
    h = ONE;
    x[0] = ID_X;
    xprev0 = '0;
    apply();
    expect_now(0, ID_X, "identity");
    xprev0 = ID_X;
    apply();
    expect_now(0, '0, "x_xor_xprev_zero");

    // Zero key, then hold with changing inputs
    h = '0;
    x[0] = rnd128();
    xprev0 = rnd128();
    apply();
    expect_now(0, '0, "zero_key");
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      apply();
      expect_now(0, '0, "hold");
    end

    // Five-stage chain from reset
    rst = 1'b1;
    apply();
    rst = 1'b0;
    valid = 1'b1;
    load_chain();
    for (int i = 0; i < NS; i++) apply();
    for (int i = 0; i < 3; i++) begin
      expect_now(NS-1, CH_OUT, "chain_out");
      apply();
    end
    expect_now(NS-1, CH_OUT, "chain_stable");

    // Hold mid-stream for 3 cycles, then resume
    rst = 1'b1;
    apply();
    rst = 1'b0;
    apply();
    apply();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) apply();
    valid = 1'b1;
    for (int i = 0; i < 3; i++) apply();
    expect_now(NS-1, CH_OUT, "resume_out");
    apply();
    expect_now(NS-1, CH_OUT, "resume_stable");

    // Random triples with occasional hold and reset
    for (int i = 0; i < 1000; i++) begin
      randomize_inputs();
      valid = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 63) == 0);
      apply();
    end
    rst = 1'b0;
    valid = 1'b0;
    apply();

    end_check = 1'b1;
    for (int i = 0; i < 4 && !end_done; i++) @(negedge clk);
    #1;
    if (!end_done) begin
      miscompares++;
      $display("FAIL monitor_timeout: got no drain check want drain check");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
